// File: rtl/aes_spi_sequencer.sv
// aes_spi_sequencer: clk-domain SPI front end and start/done sequencer for the
// AES-128 core. Collects a 256-bit {plaintext, key} frame from an oversampled
// SPI port, fires one start pulse, waits for the core (with a timeout), and
// shifts the 128-bit cyphertext back out on sdo, MSB first.
module aes_spi_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sck,
   input  logic         sdi,
   input  logic         load,
   output logic         sdo,
   output logic         done,
   output logic         frame_err,
   output logic         aes_start,
   output logic [127:0] aes_key,
   output logic [127:0] aes_plaintext,
   input  logic         aes_done,
   input  logic [127:0] aes_cyphertext
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_START,
      S_WAIT,
      S_SEND
   } state_e;

   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] sdi_sync_q;
   logic [SYNC_STAGES-1:0] load_sync_q;
   logic                   sck_prev_q;
   logic                   load_prev_q;

   logic sck_s, sdi_s, load_s;
   logic sck_rise, sck_fall, load_rise, load_fall;

   state_e         state_q, state_d;
   logic [255:0]   frame_q, frame_d;
   logic [8:0]     bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [127:0]   out_sr_q, out_sr_d;
   logic [127:0]   key_q, key_d;
   logic [127:0]   pt_q, pt_d;
   logic           err_q, err_d;

   // Bring the SPI pins into clk and keep a one-cycle-old copy for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q  <= '0;
         sdi_sync_q  <= '0;
         load_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         load_prev_q <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
         load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load};
         sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
         load_prev_q <= load_sync_q[SYNC_STAGES-1];
      end
   end

   assign sck_s     = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign load_s    = load_sync_q[SYNC_STAGES-1];
   assign sck_rise  = sck_s & ~sck_prev_q;
   assign sck_fall  = ~sck_s & sck_prev_q;
   assign load_rise = load_s & ~load_prev_q;
   assign load_fall = ~load_s & load_prev_q;

   // Next-state and output decode; load_fall wins over a coincident sck edge
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_cnt_d = bit_cnt_q;
      tmo_d     = tmo_q;
      out_sr_d  = out_sr_q;
      key_d     = key_q;
      pt_d      = pt_q;
      err_d     = err_q;
      aes_start = 1'b0;
      done      = 1'b0;
      sdo       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (load_rise) begin
               state_d   = S_RECV;
               bit_cnt_d = '0;
               err_d     = 1'b0;
            end
         end

         S_RECV: begin
            if (load_fall) begin
               if (bit_cnt_q == 9'd256) begin
                  state_d = S_START;
                  pt_d    = frame_q[255:128];
                  key_d   = frame_q[127:0];
               end else begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end else if (sck_rise && (bit_cnt_q != 9'd256)) begin
               // Once 256 bits are in, later bits are dropped so the frame stays intact
               frame_d   = {frame_q[254:0], sdi_s};
               bit_cnt_d = bit_cnt_q + 9'd1;
            end
         end

         S_START: begin
            aes_start = 1'b1;
            tmo_d     = '0;
            state_d   = S_WAIT;
         end

         S_WAIT: begin
            // A done arriving on the final allowed cycle is still accepted
            if (aes_done) begin
               out_sr_d = aes_cyphertext;
               state_d  = S_SEND;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_SEND: begin
            done = 1'b1;
            sdo  = out_sr_q[127];
            if (load_rise) begin
               state_d   = S_RECV;
               out_sr_d  = '0;
               bit_cnt_d = '0;
               err_d     = 1'b0;
            end else if (sck_fall) begin
               // The MCU samples on sck rise, so advance to the next bit on the fall
               out_sr_d = {out_sr_q[126:0], 1'b0};
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         tmo_q     <= '0;
         out_sr_q  <= '0;
         key_q     <= '0;
         pt_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_q     <= tmo_d;
         out_sr_q  <= out_sr_d;
         key_q     <= key_d;
         pt_q      <= pt_d;
         err_q     <= err_d;
      end
   end

   // Frame shift register; contents only matter once the bit counter says so
   always_ff @(posedge clk) begin
      frame_q <= frame_d;
   end

   assign aes_key       = key_q;
   assign aes_plaintext = pt_q;
   assign frame_err     = err_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Bench for aes_spi_sequencer: drives SPI frames, models the AES core, and
// compares the sequencer against phase-level expectations every cycle.
`timescale 1ns/1ps
module tb_aes_spi_sequencer;

   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 1024;

   localparam logic [127:0] A1_PT  = 128'h3243F6A8885A308D313198A2E0370734;
   localparam logic [127:0] A1_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
   localparam logic [127:0] A1_CT  = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] C1_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

   logic         clk;
   logic         reset, sck, sdi, load, aes_done;
   logic         sdo, done, frame_err, aes_start;
   logic [127:0] aes_key, aes_plaintext, aes_cyphertext;

   int checks    = 0;
   int failures  = 0;
   int start_cnt = 0;
   int half       = 4;
   int core_delay = 5;
   int core_hold  = 1;
   logic core_hang = 1'b0;

   // phase-level expectations, compared every cycle while m_valid is set
   logic         m_valid = 1'b0;
   logic         m_done  = 1'b0;
   logic         m_err   = 1'b0;
   logic [127:0] m_key   = '0;
   logic [127:0] m_pt    = '0;

   aes_spi_sequencer #(
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sck           (sck),
      .sdi           (sdi),
      .load          (load),
      .sdo           (sdo),
      .done          (done),
      .frame_err     (frame_err),
      .aes_start     (aes_start),
      .aes_key       (aes_key),
      .aes_plaintext (aes_plaintext),
      .aes_done      (aes_done),
      .aes_cyphertext(aes_cyphertext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Stand-in for the AES core: known vectors for FIPS-197, a cheap mix otherwise
   function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
      if (pt == A1_PT && key == A1_KEY) return A1_CT;
      if (pt == C1_PT && key == C1_KEY) return C1_CT;
      return pt ^ {key[63:0], key[127:64]} ^ 128'hA5A5_0F0F_5A5A_F0F0_1234_5678_9ABC_DEF0;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Per-cycle compare against the model, plus a start-pulse counter
   always @(negedge clk) begin
      if (aes_start === 1'b1) start_cnt++;
      if (m_valid) begin
         chk1("done", done, m_done);
         chk1("frame_err", frame_err, m_err);
         chk1("aes_start_quiet", aes_start, 1'b0);
         if (!m_done) chk1("sdo_quiet", sdo, 1'b0);
         chk128("aes_key", aes_key, m_key);
         chk128("aes_plaintext", aes_plaintext, m_pt);
      end
   end

   // Core model: answers each start after core_delay cycles, holds done core_hold cycles
   initial begin
      logic [127:0] r;
      aes_done       = 1'b0;
      aes_cyphertext = '0;
      forever begin
         @(negedge clk);
         if (aes_start === 1'b1 && !core_hang) begin
            r = core_fn(aes_plaintext, aes_key);
            repeat (core_delay) @(posedge clk);
            #1;
            aes_done       = 1'b1;
            aes_cyphertext = r;
            repeat (core_hold) @(posedge clk);
            #1;
            aes_done       = 1'b0;
            aes_cyphertext = rnd128();
         end
      end
   end

   task automatic send_frame(input logic [255:0] f, input int nbits, input int abort_at);
      m_valid = 1'b0;
      load    = 1'b1;
      tick(half + 2);
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_valid = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         if (i == abort_at) begin
            m_valid = 1'b0;
            reset = 1'b1; load = 1'b0; sck = 1'b0; sdi = 1'b0;
            tick(1);
            chk1("rst_sdo", sdo, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_frame_err", frame_err, 1'b0);
            chk1("rst_aes_start", aes_start, 1'b0);
            chk128("rst_aes_key", aes_key, '0);
            chk128("rst_aes_plaintext", aes_plaintext, '0);
            reset = 1'b0;
            m_key = '0;
            m_pt  = '0;
            tick(half + 2);
            m_valid = 1'b1;
            return;
         end
         sdi = (i < 256) ? f[255 - i] : 1'($urandom);
         tick(half);
         sck = 1'b1;
         tick(half);
         sck = 1'b0;
      end
      tick(half);
      m_valid = 1'b0;
      load    = 1'b0;
   endtask

   task automatic wait_start(input int s0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (start_cnt != s0) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic read_out(input int n, input logic [127:0] cy, output logic [127:0] rd);
      logic exp_bit;
      rd = '0;
      for (int k = 0; k < n; k++) begin
         tick(half);
         exp_bit = (k < 128) ? cy[127 - k] : 1'b0;
         chk1($sformatf("sdo_bit%0d", k), sdo, exp_bit);
         if (k < 128) rd[127 - k] = sdo;
         sck = 1'b1;
         tick(half);
         sck = 1'b0;
      end
      tick(half);
   endtask

   task automatic run_frame(input logic [127:0] pt, input logic [127:0] key,
                            input int nbits, input int nread, output logic [127:0] rd);
      int s0;
      bit ok;
      s0 = start_cnt;
      send_frame({pt, key}, nbits, -1);
      wait_start(s0, ok);
      chk1("start_seen", ok, 1'b1);
      tick(3);
      chk128("start_pulses", 128'(start_cnt - s0), 128'(1));
      chk128("aes_plaintext_at_start", aes_plaintext, pt);
      chk128("aes_key_at_start", aes_key, key);
      m_pt  = pt;
      m_key = key;
      wait_done(core_delay + core_hold + 40, ok);
      chk1("done_seen", ok, 1'b1);
      m_done  = 1'b1;
      m_err   = 1'b0;
      m_valid = 1'b1;
      read_out(nread, core_fn(pt, key), rd);
   endtask

   task automatic run_short(input int nbits);
      int s0;
      s0 = start_cnt;
      send_frame({rnd128(), rnd128()}, nbits, -1);
      tick(20);
      chk128("short_no_start", 128'(start_cnt - s0), 128'(0));
      chk1("short_frame_err", frame_err, 1'b1);
      chk1("short_done", done, 1'b0);
      m_err   = 1'b1;
      m_done  = 1'b0;
      m_valid = 1'b1;
      // sck activity while idle must not disturb anything
      for (int i = 0; i < 5; i++) begin
         sck = 1'b1;
         tick(half);
         sck = 1'b0;
         tick(half);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] got, p, k;
      int s0;
      bit ok;
      reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0;
      tick(3);
      chk1("reset_sdo", sdo, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_frame_err", frame_err, 1'b0);
      chk1("reset_aes_start", aes_start, 1'b0);
      chk128("reset_aes_key", aes_key, '0);
      chk128("reset_aes_plaintext", aes_plaintext, '0);
      reset = 1'b0;
      tick(5);
      m_valid = 1'b1;
      tick(10);

      // FIPS-197 A.1, pulse-style done
      half = 4; core_delay = 7; core_hold = 1;
      run_frame(A1_PT, A1_KEY, 256, 128, got);
      chk128("a1_readback", got, 128'h3925841D02DC09FBDC118597196A0B32);
      chk128("a1_key_literal", aes_key, 128'h2B7E151628AED2A6ABF7158809CF4F3C);

      // FIPS-197 C.1 back to back, level-style done
      core_delay = 20; core_hold = 3;
      run_frame(C1_PT, C1_KEY, 256, 128, got);
      chk128("c1_readback", got, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);

      // short frame, then a full frame clears the error
      run_short(255);
      p = rnd128(); k = rnd128();
      core_delay = 3; core_hold = 1;
      run_frame(p, k, 256, 128, got);
      chk128("after_short_readback", got, core_fn(p, k));

      // core hang: timeout returns to idle with frame_err
      core_hang = 1'b1;
      p = rnd128(); k = rnd128();
      s0 = start_cnt;
      send_frame({p, k}, 256, -1);
      wait_start(s0, ok);
      chk1("hang_start_seen", ok, 1'b1);
      m_pt = p; m_key = k; m_done = 1'b0; m_err = 1'b0; m_valid = 1'b1;
      tick(990);
      m_valid = 1'b0;
      chk1("hang_err_before_timeout", frame_err, 1'b0);
      tick(50);
      chk1("hang_err_after_timeout", frame_err, 1'b1);
      chk1("hang_done_low", done, 1'b0);
      m_err = 1'b1; m_valid = 1'b1;
      tick(10);
      core_hang = 1'b0;

      // done on the last allowed wait cycle still wins over the timeout
      core_delay = TIMEOUT; core_hold = 1;
      p = rnd128(); k = rnd128();
      run_frame(p, k, 256, 128, got);
      chk128("late_done_readback", got, core_fn(p, k));

      // overrun: 300 sck edges, only the first 256 bits count
      core_delay = 4;
      p = rnd128(); k = rnd128();
      run_frame(p, k, 300, 128, got);

      // 130 readout clocks: trailing bits read 0
      p = rnd128(); k = rnd128();
      run_frame(p, k, 256, 130, got);

      // reset at bit 100, then a clean A.1
      send_frame({A1_PT, A1_KEY}, 256, 100);
      run_frame(A1_PT, A1_KEY, 256, 128, got);
      chk128("a1_after_reset_readback", got, 128'h3925841D02DC09FBDC118597196A0B32);

      // randomized frames
      for (int r = 0; r < 4; r++) begin
         half       = $urandom_range(4, 6);
         core_delay = $urandom_range(1, 60);
         core_hold  = $urandom_range(1, 3);
         p = rnd128(); k = rnd128();
         if ($urandom_range(0, 4) == 0) run_short($urandom_range(1, 255));
         else run_frame(p, k, $urandom_range(256, 270), $urandom_range(100, 132), got);
      end

      m_valid = 1'b0;
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
